// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter: op codes,
// FSM state encoding and field widths.
package alu_share_arbiter_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ID_W  = 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0000;
  localparam logic [OP_W-1:0] OP_LUI  = 4'b1000;
  localparam logic [OP_W-1:0] OP_ORI  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLLI = 4'b1100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of both requesters of the ALU sharing arbiter.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [OP_W-1:0]   req0_op_i;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;
  logic              rsp0_valid_o;
  logic              rsp0_ready_i;
  logic [DATA_W-1:0] rsp0_result_o;
  logic              rsp0_zero_o;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [OP_W-1:0]   req1_op_i;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;
  logic              rsp1_valid_o;
  logic              rsp1_ready_i;
  logic [DATA_W-1:0] rsp1_result_o;
  logic              rsp1_zero_o;

  // Requester side
  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o
  );

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
    output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
    output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o
  );

endinterface

// File: rtl/alu_share_arbiter_rr_grant2.sv
// Two-input round-robin grant: a lone valid wins; on contention the pointer
// picks the winner. Purely combinational.
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (valid == 2'b11) begin
      grant_c[ptr] = 1'b1;
    end else begin
      grant_c = valid;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: round-robin
// accept, hold latched operands for EXEC_CYCLES, then hold the response.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave bus,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  logic [1:0]             state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [DATA_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      b_q, b_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]             rsp_zero_q, rsp_zero_d;

  logic [1:0] grant_c;
  logic       idle_c;
  logic       owner_ready_c;

  rr_grant2 u_grant (
    .valid   ({bus.req1_valid_i, bus.req0_valid_i}),
    .ptr     (ptr_q),
    .grant_c (grant_c)
  );

  assign idle_c        = (state_q == ST_IDLE);
  assign owner_ready_c = (owner_q == ID_W'(1)) ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  assign bus.req0_ready_o = idle_c & grant_c[0];
  assign bus.req1_ready_o = idle_c & grant_c[1];

  // Next-state and register-update logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_c != 2'b00) begin
          if (grant_c[1]) begin
            op_d = bus.req1_op_i;
            a_d  = bus.req1_a_i;
            b_d  = bus.req1_b_i;
          end else begin
            op_d = bus.req0_op_i;
            a_d  = bus.req0_a_i;
            b_d  = bus.req0_b_i;
          end
          owner_d = ID_W'(grant_c[1]);
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          rsp_valid_d[owner_q]  = 1'b1;
          rsp_result_d[owner_q] = alu_result_i;
          rsp_zero_d[owner_q]   = alu_zero_i;
          state_d               = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (owner_ready_c) begin
          rsp_valid_d[owner_q] = 1'b0;
          ptr_d                = ~owner_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_op_o = op_q;
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;

  assign bus.rsp0_valid_o  = rsp_valid_q[0];
  assign bus.rsp0_result_o = rsp_result_q[0];
  assign bus.rsp0_zero_o   = rsp_zero_q[0];
  assign bus.rsp1_valid_o  = rsp_valid_q[1];
  assign bus.rsp1_result_o = rsp_result_q[1];
  assign bus.rsp1_zero_o   = rsp_zero_q[1];

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, for example the core datapath and an address/immediate helper path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, latches operands, drives the ALU for a programmable number of settle cycles, and captures the result and zero flag.
- It holds the response until it is accepted. It sits beside the ALU instance, and the ALU ports connect directly to the alu_* signals.

Parameters:
- DATA_W, 32, operand and result width.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is captured (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has an operation pending.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_op_i  input  4  ALU operation code.
- req0_a_i  input  DATA_W  operand A.
- req0_b_i  input  DATA_W  operand B.
- rsp0_valid_o  output  1  result for requester 0 available.
- rsp0_ready_i  input  1  requester 0 consumes the result.
- rsp0_result_o  output  DATA_W  captured ALU result.
- rsp0_zero_o  output  1  captured zero flag.
- req1_* and rsp1_*: same widths and meaning as requester 0.
- alu_op_o  output  4  to ALU_Operation_i.
- alu_a_o  output  DATA_W  to A_i.
- alu_b_o  output  DATA_W  to B_i.
- alu_result_i  input  DATA_W  from ALU_Result_o.
- alu_zero_i  input  1  from Zero_o.

Behaviour:
- Single clock, clk. Asynchronous active-low reset on reset.
- Reset values:
  - state IDLE.
  - priority pointer = 0 (requester 0 favoured).
  - op/A/B registers = 0, so alu_op_o = 0, alu_a_o = 0, alu_b_o = 0.
  - rsp*_valid_o = 0, rsp*_result_o = 0, rsp*_zero_o = 0.
  - cycle counter = 0.
- FSM states:
  - IDLE:
    - Grant = the valid requester. If both are valid, grant the one selected by the priority pointer.
    - reqN_ready_o = 1 combinationally, only in IDLE and only for the granted N.
    - On accept: latch op/A/B, record the owner, load counter = EXEC_CYCLES-1, go to EXEC.
    - No valid request: stay in IDLE; registers hold.
  - EXEC:
    - alu_* outputs driven from the latched registers.
    - If counter = 0: capture alu_result_i and alu_zero_i into the owner's rsp registers, set rspN_valid_o, go to RESP.
    - Otherwise decrement the counter.
  - RESP:
    - rspN_valid_o, result and zero stay stable until rspN_ready_i = 1.
    - On the handshake cycle: clear valid, set pointer = other requester, go to IDLE.
- Latency: accept at cycle N gives rsp_valid at N+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles.
- No new request is accepted in EXEC or RESP; both ready outputs are 0.
- If rsp_ready is already high when valid rises, the transfer completes that same cycle; one RESP cycle is minimum.
- Unsupported op codes pass through unchanged; the result is whatever the ALU returns (0, zero = 1).
- alu_* outputs keep their last latched values in IDLE and RESP, and never glitch to the unlatched request inputs.
- Only the owner's rsp channel asserts valid; the other channel's valid stays 0.
- A reset assertion during EXEC or RESP discards the transaction; no response is produced after release.
- Requester behaviour after valid is asserted is not checked; operands are sampled only on the accept cycle.

Decomposition:
- Shared package holds:
  - op-code constants: ADD/ADDI = 4'b0000, LUI = 4'b1000, ORI = 4'b1001, SLLI = 4'b1100.
  - FSM state encoding: IDLE, EXEC, RESP.
  - requester-ID width constant.
- One sub-module, rr_grant2: two-input round-robin grant from the valid inputs and the pointer. It is purely combinational and reusable by later shared-resource arbiters.

Test Plan:
- Reset released, req0: ADD, A = 5, B = 7 -> req0_ready_o pulses one cycle; rsp0_valid_o two cycles after accept; rsp0_result_o = 12; rsp0_zero_o = 0; rsp1_valid_o stays 0.
- req1: ADD, A = 5, B = -5 (32'hFFFFFFFB) -> rsp1_result_o = 0, rsp1_zero_o = 1.
- Both valid on the first cycle after reset (req0 ADD 1+1, req1 ADD 2+2):
  - req0 served first, result 2.
  - req1 served next, result 4.
  - Repeat with both valid: req0 first again, since the pointer went back to 0 after req1.
- Backpressure: rsp0_ready_i low for 4 cycles after valid -> valid, result and zero stable; both req_ready = 0; completes on the first ready cycle; state returns to IDLE.
- EXEC_CYCLES = 3, ADD A = 32'h7FFFFFFF, B = 1 -> rsp valid 4 cycles after accept; result = 32'h80000000.
- Reset asserted in the second EXEC cycle -> all outputs return to their reset values asynchronously; no response after release; the next request is served normally.
